// File: rtl/div_arbiter_if.sv
// Handshake bundle between the divider arbiter, its two requesters and the shared divider.
// The arbiter uses the master modport; the environment (requesters plus divider) uses slave.
interface div_arbiter_if #(
    parameter int WA = 64,
    parameter int WB = 32
);
    // valid/ready: a transfer happens on a rising edge where valid and ready are both high;
    // valid, once raised, holds its payload until that edge; ready may depend on valid.
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [2*WA-1:0] req_a;
    logic [2*WB-1:0] req_b;
    logic [1:0]      rsp_valid;
    logic [1:0]      rsp_ready;
    logic [WB-1:0]   rsp_q;
    logic [WB-1:0]   rsp_r;
    logic            rsp_dz;
    logic            rsp_do;
    logic            rsp_err;
    logic            div_start;
    logic [WA-1:0]   div_a;
    logic [WB-1:0]   div_b;
    logic            div_done;
    logic [WB-1:0]   div_q;
    logic [WB-1:0]   div_r;
    logic            div_dz;
    logic            div_do;

    modport master (
        input  req_valid, req_a, req_b, rsp_ready,
        input  div_done, div_q, div_r, div_dz, div_do,
        output req_ready, rsp_valid, rsp_q, rsp_r, rsp_dz, rsp_do, rsp_err,
        output div_start, div_a, div_b
    );

    modport slave (
        output req_valid, req_a, req_b, rsp_ready,
        output div_done, div_q, div_r, div_dz, div_do,
        input  req_ready, rsp_valid, rsp_q, rsp_r, rsp_dz, rsp_do, rsp_err,
        input  div_start, div_a, div_b
    );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one iterative divider between two requesters;
// one job in flight: accept, launch, wait for done (or time out), respond to the winner.
module div_arbiter #(
    parameter int WA      = 64,
    parameter int WB      = 32,
    parameter int TIMEOUT = 40
) (
    input  logic          clk,
    input  logic          rst,
    div_arbiter_if.master bus,
    output logic [1:0]    o_dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        r_state;
    state_t        w_next;
    logic          r_grant;
    logic          r_last_grant;
    logic [WA-1:0] r_div_a;
    logic [WB-1:0] r_div_b;
    logic [WB-1:0] r_q;
    logic [WB-1:0] r_r;
    logic          r_dz;
    logic          r_do;
    logic          r_err;
    logic [CW-1:0] r_cnt;

    logic          w_win;
    logic [1:0]    w_req_ready;
    logic          w_accept;
    logic [WA-1:0] w_a_sel;
    logic [WB-1:0] w_b_sel;
    logic          w_rsp_fire;
    logic          w_timeout;

    // On contention the port that did not win last time gets the grant.
    assign w_win       = (&bus.req_valid) ? ~r_last_grant : bus.req_valid[1];
    assign w_req_ready = (r_state == S_IDLE && |bus.req_valid) ? (w_win ? 2'b10 : 2'b01) : 2'b00;
    assign w_accept    = |(bus.req_valid & w_req_ready);
    assign w_a_sel     = w_win ? bus.req_a[WA +: WA] : bus.req_a[0 +: WA];
    assign w_b_sel     = w_win ? bus.req_b[WB +: WB] : bus.req_b[0 +: WB];
    assign w_rsp_fire  = (r_state == S_RESP) && bus.rsp_ready[r_grant];
    assign w_timeout   = (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = (w_b_sel == '0) ? S_RESP : S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (bus.div_done || w_timeout) w_next = S_RESP;
            S_RESP:  if (w_rsp_fire) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_div_a      <= '0;
            r_div_b      <= '0;
            r_q          <= '0;
            r_r          <= '0;
            r_dz         <= 1'b0;
            r_do         <= 1'b0;
            r_err        <= 1'b0;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_div_a      <= w_a_sel;
                        r_div_b      <= w_b_sel;
                        r_grant      <= w_win;
                        r_last_grant <= w_win;
                        // Zero divisor never reaches the divider; answer directly.
                        if (w_b_sel == '0) begin
                            r_q   <= '0;
                            r_r   <= '0;
                            r_dz  <= 1'b1;
                            r_do  <= 1'b0;
                            r_err <= 1'b0;
                        end
                    end
                end
                S_ISSUE: r_cnt <= '0;
                S_WAIT: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (bus.div_done) begin
                        r_q   <= bus.div_q;
                        r_r   <= bus.div_r;
                        r_dz  <= bus.div_dz;
                        r_do  <= bus.div_do;
                        r_err <= 1'b0;
                    end else if (w_timeout) begin
                        r_q   <= '0;
                        r_r   <= '0;
                        r_dz  <= 1'b0;
                        r_do  <= 1'b0;
                        r_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = (r_state == S_RESP) ? (r_grant ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rsp_q     = r_q;
    assign bus.rsp_r     = r_r;
    assign bus.rsp_dz    = r_dz;
    assign bus.rsp_do    = r_do;
    assign bus.rsp_err   = r_err;
    assign bus.div_start = (r_state == S_ISSUE);
    assign bus.div_a     = r_div_a;
    assign bus.div_b     = r_div_b;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: behavioural 33-cycle divider, requester/consumer driver tasks,
// and a scoreboard of expected responses {rsp_valid, q, r, dz, do, err}.
module tb_div_arbiter;
    localparam int WA = 64, WB = 32, TIMEOUT = 40, LAT = 33, SBW = 69;

    logic clk = 1'b0;
    logic rst;
    logic [1:0] dbg_state;
    always #5 clk = ~clk;

    div_arbiter_if #(.WA(WA), .WB(WB)) bus ();

    div_arbiter #(.WA(WA), .WB(WB), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .bus(bus), .o_dbg_state(dbg_state)
    );

    int total = 0;
    int bad = 0;
    logic [SBW-1:0] exp_q[$];

    int start_cnt = 0;
    int done_cnt = 0;
    bit model_en = 1'b1;
    int m_cnt = 0;
    logic [WA-1:0] m_a;
    logic [WB-1:0] m_b;

    // Divider model: done arrives LAT cycles after the start pulse; model_en=0 never answers.
    always @(negedge clk) begin : divider_model
        logic signed [63:0] sa, quot, rem;
        logic signed [31:0] sb;
        bus.div_done = 1'b0;
        if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0 && model_en) begin
                sa = m_a;
                sb = m_b;
                quot = sa / sb;
                rem  = sa % sb;
                bus.div_q  = quot[31:0];
                bus.div_r  = rem[31:0];
                bus.div_dz = 1'b0;
                bus.div_do = (quot != {{32{quot[31]}}, quot[31:0]});
                bus.div_done = 1'b1;
                done_cnt++;
            end
        end
        if (bus.div_start === 1'b1) begin
            start_cnt++;
            m_cnt = LAT;
            m_a = bus.div_a;
            m_b = bus.div_b;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [SBW-1:0] mk_exp(input int port, input logic [31:0] q, input logic [31:0] r,
                                               input logic dz, input logic dov, input logic err);
        logic [1:0] oh;
        oh = (port == 1) ? 2'b10 : 2'b01;
        return {oh, q, r, dz, dov, err};
    endfunction

    function automatic logic [SBW-1:0] obs_now();
        return {bus.rsp_valid, bus.rsp_q, bus.rsp_r, bus.rsp_dz, bus.rsp_do, bus.rsp_err};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;
        bus.req_a = '0;
        bus.req_b = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Returns just after the accepting edge (posedge + 1).
    task automatic send_req(input int port, input logic [63:0] a, input logic [31:0] b, output bit ok);
        ok = 1'b0;
        bus.req_a[port*WA +: WA] = a;
        bus.req_b[port*WB +: WB] = b;
        bus.req_valid[port] = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.req_ready[port]) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1 bus.req_valid[port] = 1'b0;
    endtask

    // Waits for a response, records it and its latency in cycles, then consumes it.
    task automatic get_rsp(input int max_cyc, output logic [SBW-1:0] obs, output int lat, output bit ok);
        ok = 1'b0;
        lat = 0;
        obs = '0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            lat++;
            if (bus.rsp_valid != 2'b00) begin
                obs = obs_now();
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            bus.rsp_ready = bus.rsp_valid;
            @(posedge clk);
            #1 bus.rsp_ready = 2'b00;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;
        bus.req_a = '0;
        bus.req_b = '0;
        @(posedge clk);
        #1;
        total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
        total++; if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 2'b00 || bus.div_start !== 1'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b/%b/%b exp=00/00/0", bus.req_ready, bus.rsp_valid, bus.div_start); end
        total++; if ({bus.rsp_q, bus.rsp_r, bus.rsp_dz, bus.rsp_do, bus.rsp_err} !== '0) begin
            bad++; $display("FAIL reset_rsp got=%h exp=0", {bus.rsp_q, bus.rsp_r, bus.rsp_dz, bus.rsp_do, bus.rsp_err}); end
        total++; if ({bus.div_a, bus.div_b} !== '0) begin
            bad++; $display("FAIL reset_ops got=%h exp=0", {bus.div_a, bus.div_b}); end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_single();
        logic [SBW-1:0] obs, exp_v;
        int lat, s0;
        bit ok;
        s0 = start_cnt;
        send_req(0, 64'd100, 32'd7, ok);
        exp_q.push_back(mk_exp(0, 32'd14, 32'd2, 1'b0, 1'b0, 1'b0));
        total++; if (!ok) begin bad++; $display("FAIL single_accept got=no_ready exp=ready"); end
        get_rsp(100, obs, lat, ok);
        exp_v = exp_q.pop_front();
        total++; if (!ok || obs !== exp_v) begin bad++; $display("FAIL single_rsp got=%h exp=%h", obs, exp_v); end
        total++; if (lat !== LAT + 2) begin bad++; $display("FAIL single_latency got=%0d exp=%0d", lat, LAT + 2); end
        total++; if (start_cnt - s0 !== 1) begin bad++; $display("FAIL single_starts got=%0d exp=1", start_cnt - s0); end
        total++; if (m_a !== 64'd100 || m_b !== 32'd7) begin bad++; $display("FAIL single_operands got=%0d/%0d exp=100/7", m_a, m_b); end
        total++; if (bus.rsp_valid !== 2'b00) begin bad++; $display("FAIL single_rsp_drop got=%b exp=00", bus.rsp_valid); end
    endtask

    task automatic test_contention();
        logic [SBW-1:0] obs, exp_v;
        int lat, p;
        bit ok;
        logic [1:0] rdy;
        do_reset();
        bus.req_a = {64'hFFFF_FFFF_FFFF_FFCE, 64'd200};
        bus.req_b = {32'd6, 32'd10};
        bus.req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            p = i % 2;
            rdy = 2'b00;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                rdy = bus.req_ready;
                if (rdy != 2'b00) break;
            end
            total++; if (rdy !== ((p == 1) ? 2'b10 : 2'b01)) begin bad++; $display("FAIL contend_grant%0d got=%b exp=%0d", i, rdy, p); end
            if (p == 0) exp_q.push_back(mk_exp(0, 32'd20, 32'd0, 1'b0, 1'b0, 1'b0));
            else        exp_q.push_back(mk_exp(1, 32'hFFFF_FFF8, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0));
            @(posedge clk);
            #1;
            if (i == 3) bus.req_valid = 2'b00;
            get_rsp(100, obs, lat, ok);
            if (i == 2) bus.req_valid = 2'b11;
            exp_v = exp_q.pop_front();
            total++; if (!ok || obs !== exp_v) begin bad++; $display("FAIL contend_rsp%0d got=%h exp=%h", i, obs, exp_v); end
        end
        bus.req_valid = 2'b00;
    endtask

    task automatic test_negative();
        logic [SBW-1:0] obs, exp_v;
        int lat;
        bit ok;
        send_req(1, 64'hFFFF_FFFF_FFFF_FF9C, 32'd7, ok);
        exp_q.push_back(mk_exp(1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0));
        get_rsp(100, obs, lat, ok);
        exp_v = exp_q.pop_front();
        total++; if (!ok || obs !== exp_v) begin bad++; $display("FAIL negative_rsp got=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_div_zero();
        logic [SBW-1:0] obs, exp_v;
        int lat, s0;
        bit ok;
        s0 = start_cnt;
        send_req(0, 64'd12345, 32'd0, ok);
        exp_q.push_back(mk_exp(0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0));
        get_rsp(100, obs, lat, ok);
        exp_v = exp_q.pop_front();
        total++; if (!ok || obs !== exp_v) begin bad++; $display("FAIL divzero_rsp got=%h exp=%h", obs, exp_v); end
        total++; if (lat !== 1) begin bad++; $display("FAIL divzero_latency got=%0d exp=1", lat); end
        total++; if (start_cnt - s0 !== 0) begin bad++; $display("FAIL divzero_starts got=%0d exp=0", start_cnt - s0); end
    endtask

    task automatic test_timeout();
        logic [SBW-1:0] obs, exp_v;
        int lat, unstable;
        bit ok;
        model_en = 1'b0;
        send_req(0, 64'd5, 32'd3, ok);
        exp_q.push_back(mk_exp(0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1));
        lat = 0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            lat++;
            if (bus.rsp_valid != 2'b00) begin ok = 1'b1; break; end
        end
        obs = obs_now();
        exp_v = exp_q.pop_front();
        total++; if (!ok || obs !== exp_v) begin bad++; $display("FAIL timeout_rsp got=%h exp=%h", obs, exp_v); end
        total++; if (lat !== TIMEOUT + 2) begin bad++; $display("FAIL timeout_latency got=%0d exp=%0d", lat, TIMEOUT + 2); end
        bus.rsp_ready = 2'b10;
        unstable = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (obs_now() !== exp_v) unstable++;
        end
        total++; if (unstable !== 0) begin bad++; $display("FAIL timeout_hold got=%0d_changes exp=0", unstable); end
        bus.rsp_ready = 2'b01;
        @(posedge clk);
        #1 bus.rsp_ready = 2'b00;
        total++; if (bus.rsp_valid !== 2'b00 || dbg_state !== 2'd0) begin
            bad++; $display("FAIL timeout_release got=%b/%0d exp=00/0", bus.rsp_valid, dbg_state); end
        model_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic [SBW-1:0] obs, exp_v;
        int lat, d0, stray;
        bit ok;
        send_req(0, 64'd50, 32'd7, ok);
        repeat (10) @(posedge clk);
        #1;
        total++; if (dbg_state !== 2'd2) begin bad++; $display("FAIL midrst_in_wait got=%0d exp=2", dbg_state); end
        d0 = done_cnt;
        rst = 1'b1;
        #1;
        total++; if (dbg_state !== 2'd0 || bus.rsp_valid !== 2'b00 || bus.div_start !== 1'b0 || {bus.div_a, bus.div_b} !== '0) begin
            bad++; $display("FAIL midrst_outputs got=%0d/%b/%b/%h exp=0/00/0/0", dbg_state, bus.rsp_valid, bus.div_start, {bus.div_a, bus.div_b}); end
        @(posedge clk);
        #1 rst = 1'b0;
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.rsp_valid != 2'b00 || dbg_state != 2'd0) stray++;
        end
        total++; if (stray !== 0 || done_cnt == d0) begin bad++; $display("FAIL midrst_late_done got=%0d_stray/%0d_dones exp=0/1", stray, done_cnt - d0); end
        send_req(0, 64'd100, 32'd7, ok);
        exp_q.push_back(mk_exp(0, 32'd14, 32'd2, 1'b0, 1'b0, 1'b0));
        get_rsp(100, obs, lat, ok);
        exp_v = exp_q.pop_front();
        total++; if (!ok || obs !== exp_v) begin bad++; $display("FAIL midrst_after got=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_back_to_back();
        logic [SBW-1:0] obs, exp_v;
        int lat, port, ai, bi;
        longint la;
        bit ok;
        for (int n = 0; n < 8; n++) begin
            port = $urandom_range(0, 1);
            ai = $urandom_range(0, 100000);
            bi = $urandom_range(1, 500);
            if ($urandom_range(0, 1)) ai = -ai;
            if ($urandom_range(0, 1)) bi = -bi;
            la = ai;
            send_req(port, la, bi, ok);
            exp_q.push_back(mk_exp(port, ai / bi, ai % bi, 1'b0, 1'b0, 1'b0));
            get_rsp(100, obs, lat, ok);
            exp_v = exp_q.pop_front();
            total++; if (!ok || obs !== exp_v) begin bad++; $display("FAIL b2b_rsp%0d got=%h exp=%h", n, obs, exp_v); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_negative();
        test_div_zero();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
